// File: rtl/core_pipe_pkg.sv
// Shared definitions for the core pipeline stage buffers: per-boundary depths,
// per-boundary payload structs and a pointer-width helper.
package core_pipe_pkg;

  localparam int FD_DEPTH = 2;
  localparam int DE_DEPTH = 2;
  localparam int EM_DEPTH = 2;
  localparam int MW_DEPTH = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  op;
  } de_payload_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_we;
    logic        mem_re;
  } em_payload_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        wb_en;
  } mw_payload_t;

  // Pointer width for a buffer of the given depth; a depth of 1 still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/core_pipe_buf_ram.sv
// DEPTH x DATA_W storage for core_pipe_buf: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module core_pipe_buf_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/core_pipe_buf.sv
// Valid/ready circular FIFO used between core pipeline stages, with synchronous flush.
// Optional combinational pass-through when empty: define CORE_PIPE_BUF_BYPASS_EN.
//
// Handshake: a word moves on a clock edge when valid and ready are both high on
// that side; valid never depends on ready, and in_ready never depends on out_ready.
module core_pipe_buf
  import core_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              flush_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] ram_rd;
  logic              full;
  logic              push;
  logic              pop;
  logic              bypass_take;
  logic              wr_en;
  logic              rd_en;

  assign full     = (cnt_q == FULL_CNT);
  assign in_ready = !full & !rest;
  assign count    = cnt_q;

`ifdef CORE_PIPE_BUF_BYPASS_EN
  logic bypass_on;
  // Gated by in_ready so nothing is offered downstream that the buffer would not accept.
  assign bypass_on   = (cnt_q == '0) & !flush_en & in_ready;
  assign out_valid   = flush_en ? 1'b0 : (bypass_on ? in_valid : (cnt_q != '0));
  assign out_data    = bypass_on ? in_data : ram_rd;
  assign bypass_take = bypass_on & in_valid & out_ready;
`else
  assign out_valid   = (cnt_q != '0);
  assign out_data    = ram_rd;
  assign bypass_take = 1'b0;
`endif

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // A word consumed straight through the bypass never touches storage or pointers.
  assign wr_en = push & !bypass_take & !flush_en;
  assign rd_en = pop & !bypass_take;

  always_ff @(posedge clk) begin
    if (rest) begin
      wp    <= '0;
      rp    <= '0;
      cnt_q <= '0;
    end else if (flush_en) begin
      wp    <= '0;
      rp    <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        wp <= (wp == LAST_PTR) ? '0 : wp + 1'b1;
      end
      if (rd_en) begin
        rp <= (rp == LAST_PTR) ? '0 : rp + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  core_pipe_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wp),
    .wr_data (in_data),
    .rd_addr (rp),
    .rd_data (ram_rd)
  );

endmodule
